// File: rtl/tf_stream_provider_pkg.sv
// Shared constants and helpers for the twiddle-factor stream provider.
// Coefficients are built at elaboration; no floating-point hardware.
package tf_stream_provider_pkg;

  localparam int FLOAT_LEN = 32;
  localparam int LOG2N     = 13;
  localparam int N         = 1 << LOG2N;
  localparam int HALF_N    = N / 2;
  localparam int QUARTER_N = N / 4;

  localparam real PI = 3.14159265358979323846;

  function automatic logic [FLOAT_LEN-1:0] flip_sign(
    input logic [FLOAT_LEN-1:0] x,
    input logic                 f
  );
    return {x[FLOAT_LEN-1] ^ f, x[FLOAT_LEN-2:0]};
  endfunction

  // cos(2*pi*m/2^log2n) as IEEE-754 bits; binary32 is round-to-nearest-even
  function automatic logic [63:0] cos_bits(
    input int m,
    input int log2n,
    input int fl
  );
    real a;
    logic [63:0] d;
    logic [23:0] mt;
    int e;
    a = 2.0 * PI * real'(m) / real'(1 << log2n);
    d = $realtobits($cos(a));
    if (fl == 64) return d;
    if (d[62:52] == 11'd0) return {32'd0, d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    mt = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) mt = mt + 24'd1;
    if (mt[23]) begin
      e = e + 1;
      mt = '0;
    end
    return {32'd0, d[63], e[7:0], mt[22:0]};
  endfunction

endpackage

// File: rtl/tf_quarter_rom.sv
// Quarter-wave cosine ROM, N/4+1 words, synchronous read.
// Table contents are constant-folded at elaboration.
module tf_quarter_rom #(
  parameter int FLOAT_LEN = tf_stream_provider_pkg::FLOAT_LEN,
  parameter int LOG2N     = tf_stream_provider_pkg::LOG2N
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [LOG2N-2:0]     addr,
  output logic [FLOAT_LEN-1:0] dout
);
  import tf_stream_provider_pkg::*;

  localparam int QN = 1 << (LOG2N - 2);

  logic [FLOAT_LEN-1:0] tbl [QN+1];

  // the quadrant point holds -0 so derived forward zeros come out as +0
  for (genvar i = 0; i <= QN; i++) begin : g_tbl
    localparam logic [63:0] W = (i == QN) ?
      (64'(1) << (FLOAT_LEN - 1)) :
      cos_bits(i, LOG2N, FLOAT_LEN);
    assign tbl[i] = W[FLOAT_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (en) dout <= tbl[addr];
  end

endmodule

// File: rtl/tf_stream_provider.sv
// Streams N/2 radix-2 DIF twiddles for one stage through a
// 3-deep stallable pipeline: index, ROM read, sign fix-up.
module tf_stream_provider #(
  parameter int FLOAT_LEN = tf_stream_provider_pkg::FLOAT_LEN,
  parameter int LOG2N     = tf_stream_provider_pkg::LOG2N,
  parameter int STAGE     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   inverse,
  input  logic                   out_ready,
  output logic [2*FLOAT_LEN-1:0] tf_out,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy
);
  import tf_stream_provider_pkg::*;

  localparam int AW = LOG2N - 1;
  localparam int SH = STAGE - 1;
  localparam logic [AW-1:0] MASK = AW'((1 << (LOG2N - STAGE)) - 1);
  localparam logic [AW-1:0] QN_A = AW'(1 << (LOG2N - 2));
  localparam logic [AW-1:0] J_LAST = '1;

  logic run, inv, adv, accept, done;
  logic v1, v2, q1, q2, l1, l2;
  logic [AW-1:0] j, k, m, a_re, a_im, re_addr, im_addr;
  logic [FLOAT_LEN-1:0] re_c, im_c;

  assign adv    = !out_valid || out_ready;
  assign accept = start && !busy;
  assign done   = out_valid && out_ready && out_last;

  // upper k bit selects the second quadrant; m is the offset inside it
  always_comb begin
    k    = (j & MASK) << SH;
    m    = {1'b0, k[AW-2:0]};
    a_re = k[AW-1] ? QN_A - m : m;
    a_im = k[AW-1] ? m : QN_A - m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      run  <= 1'b0;
      inv  <= 1'b0;
      j    <= '0;
    end else if (accept) begin
      busy <= 1'b1;
      run  <= 1'b1;
      inv  <= inverse;
      j    <= '0;
    end else begin
      if (done) busy <= 1'b0;
      if (adv && run) begin
        j <= j + 1'b1;
        if (j == J_LAST) run <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      q1      <= 1'b0;
      l1      <= 1'b0;
      re_addr <= '0;
      im_addr <= '0;
      v2      <= 1'b0;
      q2      <= 1'b0;
      l2      <= 1'b0;
    end else if (adv) begin
      v1      <= run;
      q1      <= k[AW-1];
      l1      <= run && (j == J_LAST);
      re_addr <= a_re;
      im_addr <= a_im;
      v2      <= v1;
      q2      <= q1;
      l2      <= l1;
    end
  end

  tf_quarter_rom #(
    .FLOAT_LEN(FLOAT_LEN),
    .LOG2N    (LOG2N)
  ) u_rom_re (
    .clk (clk),
    .en  (adv),
    .addr(re_addr),
    .dout(re_c)
  );

  tf_quarter_rom #(
    .FLOAT_LEN(FLOAT_LEN),
    .LOG2N    (LOG2N)
  ) u_rom_im (
    .clk (clk),
    .en  (adv),
    .addr(im_addr),
    .dout(im_c)
  );

  // im is always negated; inverse negates it back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      tf_out    <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_last  <= v2 && l2;
      if (v2) tf_out <= {flip_sign(re_c, q2), flip_sign(im_c, !inv)};
    end
  end

endmodule

// File: tb/tb_tf_stream_provider.sv
// Directed bench: N=16 twiddle streams for stages 1, 3 and 4.
// Expected words are hand-derived binary32 constants.
module tb_tf_stream_provider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic out_ready = 1'b1;

  logic [63:0] tf1, tf3, tf4;
  logic v1, v3, v4, l1, l3, l4, b1, b3, b4;

  int vectors = 0;
  int errors = 0;

  logic [63:0] w_fwd [8];
  logic [63:0] w_inv [8];
  logic [3:0]  pat;

  always #5 clk = ~clk;

  tf_stream_provider #(.FLOAT_LEN(32), .LOG2N(4), .STAGE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .out_ready(out_ready), .tf_out(tf1), .out_valid(v1),
    .out_last(l1), .busy(b1)
  );

  tf_stream_provider #(.FLOAT_LEN(32), .LOG2N(4), .STAGE(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .out_ready(out_ready), .tf_out(tf3), .out_valid(v3),
    .out_last(l3), .busy(b3)
  );

  tf_stream_provider #(.FLOAT_LEN(32), .LOG2N(4), .STAGE(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .out_ready(out_ready), .tf_out(tf4), .out_valid(v4),
    .out_last(l4), .busy(b4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    int cyc;
    logic stalled;
    logic [63:0] held;
    logic hl;

    // C0..C4 = 3F800000 3F6C835E 3F3504F3 3EC3EF15 80000000
    w_fwd[0] = 64'h3F800000_00000000;
    w_fwd[1] = 64'h3F6C835E_BEC3EF15;
    w_fwd[2] = 64'h3F3504F3_BF3504F3;
    w_fwd[3] = 64'h3EC3EF15_BF6C835E;
    w_fwd[4] = 64'h00000000_BF800000;
    w_fwd[5] = 64'hBEC3EF15_BF6C835E;
    w_fwd[6] = 64'hBF3504F3_BF3504F3;
    w_fwd[7] = 64'hBF6C835E_BEC3EF15;
    for (int i = 0; i < 8; i++)
      w_inv[i] = w_fwd[i] ^ 64'h00000000_80000000;
    pat = 4'b1001;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(v1), 64'(0));
    chk("rst_busy", 64'(b1), 64'(0));
    chk("rst_last", 64'(l1), 64'(0));
    chk("rst_tf", tf1, 64'(0));
    rst = 1'b0;

    // pass A: stage 1 and 3, forward, no stalls
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("a_busy", 64'(b1), 64'(1));
    for (int i = 0; i < 3; i++) begin
      chk("a_latency", 64'(v1), 64'(0));
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("a_valid", 64'(v1), 64'(1));
      chk("a_s1_word", tf1, w_fwd[i]);
      chk("a_s1_last", 64'(l1), 64'(i == 7));
      chk("a_s3_word", tf3, w_fwd[(i % 2) * 4]);
      if (i == 7) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("a_end_busy", 64'(b1), 64'(0));
    chk("a_end_valid", 64'(v1), 64'(0));
    @(negedge clk);
    chk("a_no_restart", 64'(b1), 64'(0));

    // pass B: inverse, start re-pulsed mid-pass
    inverse = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inverse = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("b_s4_word", tf4, 64'h3F800000_80000000);
      chk("b_s3_word", tf3, w_inv[(i % 2) * 4]);
      chk("b_s1_word", tf1, w_inv[i]);
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b_end_busy", 64'(b4), 64'(0));
    chk("b_end_valid", 64'(v4), 64'(0));
    chk("b_end_s1_busy", 64'(b1), 64'(0));

    // pass C: out_ready pattern 1-0-0-1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    hl = 1'b0;
    while (idx < 8 && cyc < 60) begin
      if (stalled) begin
        chk("c_hold_word", tf1, held);
        chk("c_hold_last", 64'(l1), 64'(hl));
        chk("c_hold_valid", 64'(v1), 64'(1));
      end
      out_ready = pat[cyc % 4];
      if (v1 && out_ready) begin
        chk("c_word", tf1, w_fwd[idx]);
        chk("c_last", 64'(l1), 64'(idx == 7));
        idx++;
      end
      stalled = v1 && !out_ready;
      held = tf1;
      hl = l1;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("c_transfers", 64'(idx), 64'(8));
    chk("c_end_valid", 64'(v1), 64'(0));
    chk("c_end_busy", 64'(b1), 64'(0));

    // pass D: reset after three transfers
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("d_pre_word", tf1, w_fwd[3]);
    rst = 1'b1;
    #1;
    chk("d_rst_valid", 64'(v1), 64'(0));
    chk("d_rst_busy", 64'(b1), 64'(0));
    chk("d_rst_tf", tf1, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("d_restart_busy", 64'(b1), 64'(1));
    for (int i = 0; i < 3; i++) begin
      chk("d_latency", 64'(v1), 64'(0));
      @(negedge clk);
    end
    chk("d_word0", tf1, w_fwd[0]);
    @(negedge clk);
    chk("d_word1", tf1, w_fwd[1]);
    repeat (7) @(negedge clk);
    chk("d_end_busy", 64'(b1), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
